uart_rx: RTL and testbench

UART receiver: recovers 8N1-style frames (start bit, DATA_BITS data bits LSB first, one stop bit, no parity) from an asynchronous serial line. It sits on the serial input pin and presents each received word on a parallel bus with a one-cycle valid strobe. It is the receive-side counterpart to the team's UART transmitter and shares its parameter set, so both ends of a link are configured identically.

---
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: recovers start/data/stop frames (LSB first, no parity) from an
// asynchronous serial line and presents each good word with a one-cycle strobe.
module uart_rx #(
  parameter int CLOCK_RATE     = 50000000,
  parameter int BAUD_RATE      = 9600,
  parameter int DATA_BITS      = 8,
  parameter int CYCLES_PER_BIT = CLOCK_RATE / BAUD_RATE
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int CNT_W = $clog2(CYCLES_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Sync flops reset low, so a line held low through reset never looks like an edge.
        if (prev_q && !sync2_q) begin
          state_d = ST_START;
          cnt_d   = HALF_LAST;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          if (!sync2_q) begin
            state_d = ST_DATA;
            cnt_d   = BIT_LAST;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = sync2_q;
          cnt_d          = BIT_LAST;
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        // Leaving mid stop bit lets a back-to-back start edge be caught.
        if (cnt_q == '0) begin
          if (sync2_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_BREAK: begin
        if (sync2_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and random frames, expected strobe and busy timing
// derived from the frame start cycle and the bit period.
module tb_uart_rx;
  localparam int C     = 16;
  localparam int H     = C / 2;
  localparam int DB    = 8;
  localparam int S_OFS = 2 + H + (DB + 1) * C;

  logic          clk;
  logic          rst;
  logic          rx;
  logic [DB-1:0] o_data;
  logic          o_valid;
  logic          o_frame_err;
  logic          o_busy;

  uart_rx #(
    .CLOCK_RATE    (C * 9600),
    .BAUD_RATE     (9600),
    .DATA_BITS     (DB),
    .CYCLES_PER_BIT(C)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx       (rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          err;
    logic [7:0]  data;
  } evt_t;
  typedef struct {
    int cyc;
    bit lvl;
  } bt_t;

  evt_t       evq[$];
  bt_t        bq[$];
  evt_t       ev_cur;
  bt_t        bt_cur;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] last_good = 8'h00;
  logic       busy_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: each frame's outcome lands S_OFS cycles after its start edge.
  always @(negedge clk) begin
    if (o_valid || o_frame_err) begin
      if (evq.size() == 0) begin
        chk("evt_unexpected", 32'({o_valid, o_frame_err}), 32'd0);
      end else begin
        ev_cur = evq.pop_front();
        chk("evt_cycle", cyc, ev_cur.cyc);
        chk("evt_valid", 32'(o_valid), 32'(!ev_cur.err));
        chk("evt_frame_err", 32'(o_frame_err), 32'(ev_cur.err));
        chk("o_data", 32'(o_data), 32'(ev_cur.data));
        $display("cycle %0d: %s data=0x%02h", cyc, o_valid ? "valid" : "frame_err", o_data);
      end
    end
    if (o_busy !== busy_prev) begin
      if (bq.size() == 0) begin
        chk("busy_unexpected", 32'(o_busy), 32'(busy_prev));
      end else begin
        bt_cur = bq.pop_front();
        chk("busy_cycle", cyc, bt_cur.cyc);
        chk("busy_level", 32'(o_busy), 32'(bt_cur.lvl));
      end
    end
    busy_prev <= o_busy;
  end

  task automatic hold(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    if (n > 0) #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit good, input bit expect_it);
    int e;
    e = cyc + 1;
    if (expect_it) begin
      bq.push_back('{e + 2, 1'b1});
      if (good) begin
        bq.push_back('{e + S_OFS, 1'b0});
        evq.push_back('{e + S_OFS, 1'b0, d});
        last_good = d;
      end else begin
        evq.push_back('{e + S_OFS, 1'b1, last_good});
      end
    end
    hold(1'b0, C);
    for (int i = 0; i < DB; i++) hold(d[i], C);
    if (good) begin
      hold(1'b1, C);
    end else begin
      hold(1'b0, S_OFS - (DB + 1) * C + 40);
      if (expect_it) bq.push_back('{cyc + 1 + 2, 1'b0});
      rx = 1'b1;
    end
  endtask

  task automatic glitch(input int len);
    int e;
    e = cyc + 1;
    bq.push_back('{e + 2, 1'b1});
    bq.push_back('{e + 2 + H, 1'b0});
    hold(1'b0, len);
    rx = 1'b1;
    $display("cycle %0d: glitch of %0d cycles", e, len);
  endtask

  initial begin
    int e;
    int r;
    rst = 1'b1;
    rx  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_frame_err", 32'(o_frame_err), 32'd0);
    chk("rst_o_busy", 32'(o_busy), 32'd0);
    rst = 1'b0;
    hold(1'b0, 20);
    chk("busy_held_low", 32'(o_busy), 32'd0);
    hold(1'b1, 10);
    send_frame(8'h5A, 1'b1, 1'b1);
    hold(1'b1, 5);

    send_frame(8'hA5, 1'b1, 1'b1);
    hold(1'b1, 5);

    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    hold(1'b1, 5);

    glitch(3);
    hold(1'b1, 12);

    send_frame(8'h3C, 1'b0, 1'b1);
    hold(1'b1, 10);

    // Reset mid-frame with the line low; the rest of that frame must be ignored.
    e = cyc + 1;
    bq.push_back('{e + 2, 1'b1});
    fork
      send_frame(8'h00, 1'b1, 1'b0);
      begin
        repeat (59) @(posedge clk);
        #1;
        bq.push_back('{cyc, 1'b0});
        rst = 1'b1;
        #1;
        chk("midrst_o_data", 32'(o_data), 32'd0);
        chk("midrst_o_valid", 32'(o_valid), 32'd0);
        chk("midrst_o_frame_err", 32'(o_frame_err), 32'd0);
        chk("midrst_o_busy", 32'(o_busy), 32'd0);
        last_good = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    hold(1'b1, 5);
    send_frame(8'h81, 1'b1, 1'b1);
    hold(1'b1, 5);

    for (int k = 0; k < 24; k++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        glitch(int'($urandom_range(1, 5)));
        hold(1'b1, 12);
      end else if (r == 1) begin
        send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1);
        hold(1'b1, int'($urandom_range(4, 20)));
      end else begin
        send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1);
        hold(1'b1, int'($urandom_range(0, 20)));
      end
    end

    hold(1'b1, 30);
    chk("evt_pending", evq.size(), 32'd0);
    chk("busy_pending", bq.size(), 32'd0);
    chk("o_data_final", 32'(o_data), 32'(last_good));
    chk("o_busy_final", 32'(o_busy), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: bench still running at cycle %0d, expected completion", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
